dpram_nxm_cb: RTL and testbench

//  Parametrised synchronous true dual-port RAM; successor of the fixed 32x32 dpram macro.

---
 rtl/dpram_pkg.sv | 12 +
 rtl/dpram_rd_pipe.sv | 48 ++++
 rtl/dpram_nxm_cb.sv | 114 +++++++++++
 tb/tb_dpram_nxm_cb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package dpram_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {ST_CLEAR, ST_READY} dpram_state_e;

   function automatic int addr_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port read pipeline: 1 or 2 register stages, hold on no read, OEB gating.
module dpram_rd_pipe
   import dpram_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int READ_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic             oeb,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] q;

   generate
      if (READ_LAT == 1) begin : g_lat1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q <= '0;
            end else if (en) begin
               q <= din;
            end
         end
      end else if (READ_LAT == 2) begin : g_lat2
         logic             v1;
         logic [WIDTH-1:0] d1;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v1 <= 1'b0;
               d1 <= '0;
               q  <= '0;
            end else begin
               v1 <= en;
               if (en) d1 <= din;
               if (v1) q <= d1;
            end
         end
      end else begin : g_bad
         $error("dpram_rd_pipe: READ_LAT must be 1 or 2");
      end
   endgenerate

   assign dout = oeb ? '0 : q;

endmodule

// File: rtl/dpram_nxm_cb.sv
// Synchronous true dual-port RAM with byte enables, collision flag and zero-fill sweep.
module dpram_nxm_cb
   import dpram_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int DEPTH          = 32,
   parameter int READ_LAT       = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                       CLK,
   input  logic                       RSTB,
   input  logic                       CSB1,
   input  logic                       CSB2,
   input  logic                       WEB1,
   input  logic                       WEB2,
   input  logic                       OEB1,
   input  logic                       OEB2,
   input  logic [WIDTH/8-1:0]         BWEB1,
   input  logic [WIDTH/8-1:0]         BWEB2,
   input  logic [addr_w(DEPTH)-1:0]   A1,
   input  logic [addr_w(DEPTH)-1:0]   A2,
   input  logic [WIDTH-1:0]           I1,
   input  logic [WIDTH-1:0]           I2,
   output logic [WIDTH-1:0]           O1,
   output logic [WIDTH-1:0]           O2,
   output logic                       INIT_BUSY,
   output logic                       COLLISION
);

   localparam int AW = addr_w(DEPTH);
   localparam int NB = WIDTH / BYTE_W;
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_V = (AW + 1)'(DEPTH);

   generate
      if (WIDTH % BYTE_W != 0) begin : g_bad_w
         $error("dpram_nxm_cb: WIDTH must be a multiple of 8");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   dpram_state_e     state;
   logic [AW-1:0]    ptr;
   logic             ready;
   logic             in1, in2;
   logic             rd1, rd2, wr1, wr2;
   logic [WIDTH-1:0] rdata1, rdata2;

   assign ready     = (state == ST_READY);
   assign INIT_BUSY = ~ready;
   assign in1       = {1'b0, A1} < DEPTH_V;
   assign in2       = {1'b0, A2} < DEPTH_V;
   assign rd1       = ready & ~CSB1 & WEB1;
   assign rd2       = ready & ~CSB2 & WEB2;
   assign wr1       = ready & ~CSB1 & ~WEB1 & in1;
   assign wr2       = ready & ~CSB2 & ~WEB2 & in2;
   assign rdata1    = in1 ? mem[A1] : '0;
   assign rdata2    = in2 ? mem[A2] : '0;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         ptr   <= '0;
      end else if (state == ST_CLEAR) begin
         if (ptr == LAST) begin
            state <= ST_READY;
            ptr   <= '0;
         end else begin
            ptr <= ptr + AW'(1);
         end
      end
   end

   // Port 1 bytes are applied last so they win a same-address W/W conflict
   always_ff @(posedge CLK) begin
      if (!ready) begin
         mem[ptr] <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (wr2 && !BWEB2[b]) mem[A2][b*BYTE_W +: BYTE_W] <= I2[b*BYTE_W +: BYTE_W];
         end
         for (int b = 0; b < NB; b++) begin
            if (wr1 && !BWEB1[b]) mem[A1][b*BYTE_W +: BYTE_W] <= I1[b*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         COLLISION <= 1'b0;
      end else begin
         COLLISION <= ready & ~CSB1 & ~CSB2 & in1 & (A1 == A2) & (~WEB1 | ~WEB2);
      end
   end

   dpram_rd_pipe #(.WIDTH(WIDTH), .READ_LAT(READ_LAT)) u_pipe1 (
      .clk   (CLK),
      .rst_n (RSTB),
      .en    (rd1),
      .din   (rdata1),
      .oeb   (OEB1),
      .dout  (O1)
   );

   dpram_rd_pipe #(.WIDTH(WIDTH), .READ_LAT(READ_LAT)) u_pipe2 (
      .clk   (CLK),
      .rst_n (RSTB),
      .en    (rd2),
      .din   (rdata2),
      .oeb   (OEB2),
      .dout  (O2)
   );

endmodule

// File: tb/tb_dpram_nxm_cb.sv
// Directed bench: default RAM, READ_LAT=2 variant and DEPTH=30 variant on shared inputs.
module tb_dpram_nxm_cb;

   logic        CLK = 1'b0;
   logic        RSTB;
   logic        CSB1, CSB2, WEB1, WEB2, OEB1, OEB2;
   logic [3:0]  BWEB1, BWEB2;
   logic [4:0]  A1, A2;
   logic [31:0] I1, I2;

   logic [31:0] o1_a, o2_a, o1_b, o2_b, o1_c, o2_c;
   logic        busy_a, busy_b, busy_c;
   logic        col_a, col_b, col_c;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   dpram_nxm_cb #(.WIDTH(32), .DEPTH(32), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut_a (
      .CLK(CLK), .RSTB(RSTB), .CSB1(CSB1), .CSB2(CSB2), .WEB1(WEB1), .WEB2(WEB2),
      .OEB1(OEB1), .OEB2(OEB2), .BWEB1(BWEB1), .BWEB2(BWEB2), .A1(A1), .A2(A2),
      .I1(I1), .I2(I2), .O1(o1_a), .O2(o2_a), .INIT_BUSY(busy_a), .COLLISION(col_a)
   );

   dpram_nxm_cb #(.WIDTH(32), .DEPTH(32), .READ_LAT(2), .CLEAR_ON_RESET(1)) dut_b (
      .CLK(CLK), .RSTB(RSTB), .CSB1(CSB1), .CSB2(CSB2), .WEB1(WEB1), .WEB2(WEB2),
      .OEB1(OEB1), .OEB2(OEB2), .BWEB1(BWEB1), .BWEB2(BWEB2), .A1(A1), .A2(A2),
      .I1(I1), .I2(I2), .O1(o1_b), .O2(o2_b), .INIT_BUSY(busy_b), .COLLISION(col_b)
   );

   dpram_nxm_cb #(.WIDTH(32), .DEPTH(30), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut_c (
      .CLK(CLK), .RSTB(RSTB), .CSB1(CSB1), .CSB2(CSB2), .WEB1(WEB1), .WEB2(WEB2),
      .OEB1(OEB1), .OEB2(OEB2), .BWEB1(BWEB1), .BWEB2(BWEB2), .A1(A1), .A2(A2),
      .I1(I1), .I2(I2), .O1(o1_c), .O2(o2_c), .INIT_BUSY(busy_c), .COLLISION(col_c)
   );

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      CSB1 = 1'b1; CSB2 = 1'b1; WEB1 = 1'b1; WEB2 = 1'b1;
      OEB1 = 1'b0; OEB2 = 1'b0; BWEB1 = '0; BWEB2 = '0;
      A1 = '0; A2 = '0; I1 = '0; I2 = '0;
   endtask

   task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      CSB1 = 1'b0; WEB1 = 1'b0; A1 = a; I1 = d; BWEB1 = be;
   endtask

   task automatic rd1(input logic [4:0] a);
      CSB1 = 1'b0; WEB1 = 1'b1; A1 = a;
   endtask

   task automatic rd2(input logic [4:0] a);
      CSB2 = 1'b0; WEB2 = 1'b1; A2 = a;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic count_sweep(output int n_a, output int n_c);
      n_a = 0;
      n_c = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy_a) n_a++;
         if (busy_c) n_c++;
         cyc();
      end
   endtask

   task automatic test_reset();
      int n_a, n_c;
      idle();
      RSTB = 1'b0;
      repeat (3) cyc();
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", busy_a); end
      checks++;
      if (o1_a !== 32'h0) begin errors++; $display("FAIL rst_o1: got 0x%08h expected 0", o1_a); end
      checks++;
      if (col_a !== 1'b0) begin errors++; $display("FAIL rst_col: got %b expected 0", col_a); end
      RSTB = 1'b1;
      count_sweep(n_a, n_c);
      checks++;
      if (n_a != 32) begin errors++; $display("FAIL sweep_len: got %0d expected 32", n_a); end
      checks++;
      if (n_c != 30) begin errors++; $display("FAIL sweep_len_d30: got %0d expected 30", n_c); end
      for (int i = 0; i < 32; i++) begin
         rd1(5'(i));
         cyc();
         checks++;
         if (o1_a !== 32'h0) begin
            errors++;
            $display("FAIL zero_fill[%0d]: got 0x%08h expected 0", i, o1_a);
         end
      end
      idle();
      cyc();
   endtask

   task automatic test_read_latency();
      wr1(5'h0f, 32'h7b, 4'b0000); cyc();
      wr1(5'h0a, 32'h67, 4'b0000); cyc();
      rd1(5'h0f); cyc();
      chk("lat1_rd0", o1_a, 32'h0000007b);
      chk("lat2_rd0_early", o1_b, 32'h0);
      rd1(5'h0a); cyc();
      chk("lat1_rd1", o1_a, 32'h00000067);
      chk("lat2_rd0", o1_b, 32'h0000007b);
      idle(); cyc();
      chk("lat1_hold", o1_a, 32'h00000067);
      chk("lat2_rd1", o1_b, 32'h00000067);
      cyc();
      chk("lat2_hold", o1_b, 32'h00000067);
   endtask

   task automatic test_byte_enable();
      wr1(5'd5, 32'hDEADBEEF, 4'b0000); cyc();
      wr1(5'd5, 32'h000000AA, 4'b1110); cyc();
      rd1(5'd5); cyc();
      chk("byte_merge", o1_a, 32'hDEADBEAA);
      idle(); cyc();
   endtask

   task automatic test_collision_ww();
      chk("ww_col_before", {31'b0, col_a}, 32'h0);
      wr1(5'd3, 32'h11111111, 4'b1100);
      CSB2 = 1'b0; WEB2 = 1'b0; A2 = 5'd3; I2 = 32'h22222222; BWEB2 = 4'b0000;
      cyc();
      chk("ww_col_pulse", {31'b0, col_a}, 32'h1);
      idle(); cyc();
      chk("ww_col_clear", {31'b0, col_a}, 32'h0);
      rd1(5'd3); cyc();
      chk("ww_merge", o1_a, 32'h22221111);
      idle(); cyc();
   endtask

   task automatic test_collision_rw();
      wr1(5'd7, 32'hA5A5A5A5, 4'b0000); cyc();
      wr1(5'd7, 32'h5A5A5A5A, 4'b0000);
      rd2(5'd7);
      cyc();
      chk("rw_old_data", o2_a, 32'hA5A5A5A5);
      chk("rw_col", {31'b0, col_a}, 32'h1);
      idle();
      rd2(5'd7);
      cyc();
      chk("rw_new_data", o2_a, 32'h5A5A5A5A);
      chk("rw_col_clear", {31'b0, col_a}, 32'h0);
      chk("rw_lat2_old", o2_b, 32'hA5A5A5A5);
      idle(); cyc();
   endtask

   task automatic test_back_to_back();
      rd1(5'd5); rd2(5'd5); cyc();
      chk("rr_o1", o1_a, 32'hDEADBEAA);
      chk("rr_o2", o2_a, 32'hDEADBEAA);
      rd1(5'd3); rd2(5'd7); cyc();
      chk("rr_col", {31'b0, col_a}, 32'h0);
      chk("b2b_o1", o1_a, 32'h22221111);
      chk("b2b_o2", o2_a, 32'h5A5A5A5A);
      idle(); cyc();
   endtask

   task automatic test_range_oeb();
      wr1(5'd31, 32'h31313131, 4'b0000);
      CSB2 = 1'b0; WEB2 = 1'b0; A2 = 5'd31; I2 = 32'h99999999; BWEB2 = 4'b0000;
      cyc();
      chk("oor_col_d32", {31'b0, col_a}, 32'h1);
      chk("oor_col_d30", {31'b0, col_c}, 32'h0);
      idle();
      rd1(5'd31); cyc();
      chk("a31_d32", o1_a, 32'h31313131);
      chk("a31_d30", o1_c, 32'h0);
      idle();
      OEB1 = 1'b1; #1;
      chk("oeb_gate", o1_a, 32'h0);
      OEB1 = 1'b0; #1;
      chk("oeb_hold", o1_a, 32'h31313131);
      OEB1 = 1'b1;
      rd1(5'd5); cyc();
      chk("oeb_gate_rd", o1_a, 32'h0);
      idle(); #1;
      chk("oeb_pipe_adv", o1_a, 32'hDEADBEAA);
      cyc();
   endtask

   task automatic test_reset_mid_sweep();
      int n_a, n_c;
      rd1(5'd5); rd2(5'd7); cyc();
      idle();
      RSTB = 1'b0; #1;
      chk("arst_o1", o1_a, 32'h0);
      chk("arst_o2", o2_a, 32'h0);
      cyc(); cyc();
      RSTB = 1'b1;
      repeat (10) cyc();
      chk("mid_busy", {31'b0, busy_a}, 32'h1);
      RSTB = 1'b0;
      cyc();
      RSTB = 1'b1;
      count_sweep(n_a, n_c);
      checks++;
      if (n_a != 32) begin errors++; $display("FAIL restart_len: got %0d expected 32", n_a); end
      rd1(5'd5); rd2(5'd7); cyc();
      chk("clr_a5", o1_a, 32'h0);
      chk("clr_a7", o2_a, 32'h0);
      rd1(5'd31); rd2(5'd3); cyc();
      chk("clr_a31", o1_a, 32'h0);
      chk("clr_a3", o2_a, 32'h0);
      idle(); cyc();
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_byte_enable();
      test_collision_ww();
      test_collision_rw();
      test_back_to_back();
      test_range_oeb();
      test_reset_mid_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
